// File: rtl/data_gen_pkg.sv
// Shared definitions for the multichannel synthetic ADC data generator.
// Holds the pattern-mode encodings, the line FSM state type, the LFSR seed
// and feedback taps, and the per-channel ramp offset.
package data_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_ECHO  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form of x^16+x^14+x^13+x^11+1 with a right shift: the
    // polynomial exponents map to state bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int RAMP_CH_STEP = 16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/data_gen_lfsr16.sv
// 16-bit Fibonacci LFSR shared by all channels of the generator.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset, state returns to the seed
//   load    - reload the seed (takes priority over advance)
//   advance - shift one step
//   state   - current LFSR contents
module data_gen_lfsr16
    import data_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/data_gen_multich.sv
// Multichannel synthetic ADC data generator. Each trigger produces one
// receive line of line_len samples on NUM_CH parallel offset-binary streams,
// using one of four patterns (ramp, constant, pseudo-random, delayed echo).
//
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   trig        - line start request (level-sampled in IDLE)
//   mode        - pattern select: 0 ramp, 1 const, 2 lfsr, 3 echo
//   line_len    - samples per line
//   const_val   - constant-mode sample value
//   echo_pos    - echo sample index on channel 0
//   echo_step   - additional echo delay per channel index
//   echo_amp    - echo sample value
//   data_out    - channel k at [k*DATA_W +: DATA_W], holds when not valid
//   data_valid  - data_out carries a new sample
//   line_done   - one-cycle pulse after the last sample
//   busy        - line in progress (ARM or RUN)
//   trig_miss   - one-cycle pulse for a trigger seen while busy
//
// state | meaning
// IDLE  | waiting for trig; line settings captured on acceptance
// ARM   | one cycle: clear sample index, reseed LFSR
// RUN   | one sample per cycle until line_len samples issued
// DONE  | one cycle: pulse line_done, then back to IDLE
module data_gen_multich
    import data_gen_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic [1:0]               mode,
    input  logic [CNT_W-1:0]         line_len,
    input  logic [DATA_W-1:0]        const_val,
    input  logic [CNT_W-1:0]         echo_pos,
    input  logic [CNT_W-1:0]         echo_step,
    input  logic [DATA_W-1:0]        echo_amp,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     line_done,
    output logic                     busy,
    output logic                     trig_miss
);

    localparam int TGT_W = CNT_W + 5;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    state_e state_q, state_d;

    // Shadow copies of the line settings, frozen for the whole line.
    mode_e              mode_q;
    logic [CNT_W-1:0]   len_q;
    logic [DATA_W-1:0]  cval_q;
    logic [CNT_W-1:0]   epos_q;
    logic [CNT_W-1:0]   estep_q;
    logic [DATA_W-1:0]  eamp_q;

    logic [CNT_W-1:0]   n_q, n_d;
    logic               latch;
    logic               lfsr_load;
    logic               lfsr_adv;
    logic [15:0]        lfsr_state;

    logic [NUM_CH*DATA_W-1:0] pattern;
    logic [NUM_CH*DATA_W-1:0] data_d;
    logic               valid_d;
    logic               done_d;
    logic               miss_d;

    // Sample index widened so ramp can take its low DATA_W bits even when
    // CNT_W is narrower than DATA_W.
    logic [CNT_W+15:0]  n_ext;
    assign n_ext = (CNT_W+16)'(n_q);

    data_gen_lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [DATA_W-1:0] RAMP_OFS = DATA_W'(RAMP_CH_STEP * k);
        localparam logic [DATA_W-1:0] CH_IDX   = DATA_W'(k);
        localparam logic [TGT_W-1:0]  CH_K     = TGT_W'(k);

        // Echo target computed wide enough that pos + k*step never wraps;
        // a target past the line end simply never matches n.
        logic [TGT_W-1:0]  echo_tgt;
        logic [DATA_W-1:0] samp;

        assign echo_tgt = TGT_W'(epos_q) + TGT_W'(estep_q) * CH_K;

        always_comb begin
            samp = n_ext[DATA_W-1:0] + RAMP_OFS;
            case (mode_q)
                MODE_RAMP:  samp = n_ext[DATA_W-1:0] + RAMP_OFS;
                MODE_CONST: samp = cval_q;
                MODE_LFSR:  samp = lfsr_state[DATA_W-1:0] ^ CH_IDX;
                MODE_ECHO:  samp = (TGT_W'(n_q) == echo_tgt) ? eamp_q : MIDSCALE;
                default:    samp = n_ext[DATA_W-1:0] + RAMP_OFS;
            endcase
        end

        assign pattern[k*DATA_W +: DATA_W] = samp;
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        latch     = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        data_d    = data_out;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        miss_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    latch   = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                miss_d    = trig;
                n_d       = '0;
                lfsr_load = 1'b1;
                state_d   = (len_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                miss_d   = trig;
                valid_d  = 1'b1;
                data_d   = pattern;
                lfsr_adv = 1'b1;
                n_d      = n_q + CNT_W'(1);
                if (n_q == len_q - CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // trig here is deliberately neither accepted nor flagged.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            line_done  <= 1'b0;
            trig_miss  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            data_out   <= data_d;
            data_valid <= valid_d;
            line_done  <= done_d;
            trig_miss  <= miss_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_RAMP;
            len_q   <= '0;
            cval_q  <= '0;
            epos_q  <= '0;
            estep_q <= '0;
            eamp_q  <= '0;
        end else if (latch) begin
            mode_q  <= mode_e'(mode);
            len_q   <= line_len;
            cval_q  <= const_val;
            epos_q  <= echo_pos;
            estep_q <= echo_step;
            eamp_q  <= echo_amp;
        end
    end

    assign busy = (state_q == ST_ARM) || (state_q == ST_RUN);

endmodule

// File: tb/tb_data_gen_multich.sv
module tb_data_gen_multich;

    localparam int NCH = 8;
    localparam int DW  = 12;
    localparam int CW  = 13;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              trig = 1'b0;
    logic [1:0]        mode = '0;
    logic [CW-1:0]     line_len = '0;
    logic [DW-1:0]     const_val = '0;
    logic [CW-1:0]     echo_pos = '0;
    logic [CW-1:0]     echo_step = '0;
    logic [DW-1:0]     echo_amp = '0;
    logic [NCH*DW-1:0] data_out;
    logic              data_valid;
    logic              line_done;
    logic              busy;
    logic              trig_miss;

    int n_cmp = 0;
    int n_bad = 0;
    logic [NCH*DW-1:0] exp_hold = '0;

    data_gen_multich #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .trig       (trig),
        .mode       (mode),
        .line_len   (line_len),
        .const_val  (const_val),
        .echo_pos   (echo_pos),
        .echo_step  (echo_step),
        .echo_amp   (echo_amp),
        .data_out   (data_out),
        .data_valid (data_valid),
        .line_done  (line_done),
        .busy       (busy),
        .trig_miss  (trig_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Reference sample from the pattern rules, plain integer arithmetic.
    function automatic int ref_sample(int md, int k, int n, int lf, int cv, int ep, int es, int ea);
        case (md)
            0:       return (n + 16 * k) % (1 << DW);
            1:       return cv;
            2:       return (lf % (1 << DW)) ^ k;
            default: return (n == ep + k * es) ? ea : (1 << (DW - 1));
        endcase
    endfunction

    function automatic int lfsr_step(int lf);
        int b;
        b = (lf ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1;
        return (lf >> 1) | (b << 15);
    endfunction

    task automatic run_line(input int md, input int len, input int cv, input int ep,
                            input int es, input int ea, input bit hold);
        int lf;
        int e;
        logic [NCH*DW-1:0] bus;
        lf = 'hACE1;
        mode      = 2'(md);
        line_len  = CW'(len);
        const_val = DW'(cv);
        echo_pos  = CW'(ep);
        echo_step = CW'(es);
        echo_amp  = DW'(ea);
        trig      = 1'b1;
        step();
        chk("busy_arm", 0, 64'(busy), 64'(1));
        chk("miss_accept", 0, 64'(trig_miss), 64'(0));
        if (!hold) trig = 1'b0;
        // Live inputs must not disturb the line in progress.
        mode      = 2'($urandom);
        line_len  = CW'($urandom);
        const_val = DW'($urandom);
        echo_pos  = CW'($urandom);
        echo_step = CW'($urandom);
        echo_amp  = DW'($urandom);
        step();
        chk("valid_arm", 0, 64'(data_valid), 64'(0));
        chk("miss_arm", 0, 64'(trig_miss), 64'(hold));
        for (int n = 0; n < len; n++) begin
            step();
            chk("valid_run", n, 64'(data_valid), 64'(1));
            chk("done_run", n, 64'(line_done), 64'(0));
            chk("miss_run", n, 64'(trig_miss), 64'(hold));
            for (int k = 0; k < NCH; k++) begin
                e = ref_sample(md, k, n, lf, cv, ep, es, ea);
                bus[k*DW +: DW] = DW'(e);
                chk("sample", n * 100 + k, 64'(data_out[k*DW +: DW]), 64'(e));
            end
            exp_hold = bus;
            lf = lfsr_step(lf);
        end
        step();
        chk("line_done", len, 64'(line_done), 64'(1));
        chk("valid_done", len, 64'(data_valid), 64'(0));
        chk("miss_done", len, 64'(trig_miss), 64'(0));
        chk("busy_done", len, 64'(busy), 64'(0));
        chk("hold", len, 64'(data_out), 64'(exp_hold));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_data", 0, 64'(data_out), 64'(0));
        chk("rst_valid", 0, 64'(data_valid), 64'(0));
        chk("rst_done", 0, 64'(line_done), 64'(0));
        chk("rst_busy", 0, 64'(busy), 64'(0));
        chk("rst_miss", 0, 64'(trig_miss), 64'(0));
        #3 reset = 1'b0;
        step();

        // Ramp, 5 samples
        run_line(0, 5, 0, 0, 0, 0, 1'b0);

        // Reset in the middle of a 100-sample line
        mode = 2'd0;
        line_len = CW'(100);
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (20) step();
        chk("pre_rst_valid", 0, 64'(data_valid), 64'(1));
        #3 reset = 1'b1;
        #1;
        chk("abort_data", 0, 64'(data_out), 64'(0));
        chk("abort_valid", 0, 64'(data_valid), 64'(0));
        chk("abort_busy", 0, 64'(busy), 64'(0));
        exp_hold = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", i, 64'(line_done), 64'(0));
        end
        #3 reset = 1'b0;
        step();
        chk("post_rst_done", 0, 64'(line_done), 64'(0));
        run_line(0, 5, 0, 0, 0, 0, 1'b0);

        // Ramp wrap across 4096
        run_line(0, 4100, 0, 0, 0, 0, 1'b0);

        // Echo patterns
        run_line(3, 30, 0, 10, 3, 4095, 1'b0);
        run_line(3, 30, 0, 25, 3, 4095, 1'b0);

        // LFSR on two consecutive lines, then const
        run_line(2, 20, 0, 0, 0, 0, 1'b0);
        run_line(2, 20, 0, 0, 0, 0, 1'b0);
        run_line(1, 6, 'h5A5, 0, 0, 0, 1'b0);

        // Empty line
        run_line(0, 0, 0, 0, 0, 0, 1'b0);

        // trig held through a 3-sample line, next line right after DONE
        run_line(0, 3, 0, 0, 0, 0, 1'b1);
        run_line(2, 4, 0, 0, 0, 0, 1'b0);

        // Randomised lines
        for (int r = 0; r < 10; r++) begin
            run_line(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 4095)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 8)), int'($urandom_range(0, 4095)),
                     1'($urandom_range(0, 1)));
            trig = 1'b0;
            repeat (int'($urandom_range(0, 3))) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_gen_multich.md
Name: data_gen_multich

Overview:
- Parametrised multichannel synthetic ADC data generator for the ultrasound receive-path simulation model.
- Drives NUM_CH parallel DATA_W-bit sample streams in place of the front-end ADCs, one receive line per trigger.
- Four selectable patterns: ramp, constant, pseudo-random, and delayed echo. The echo pattern exercises the downstream beamformer delay alignment.
- Adds over the fixed 8x12-bit generator: channel and width parameters, trigger/line framing, a valid strobe and pattern modes.

Parameters:
- NUM_CH, 8, number of output channels (1..16).
- DATA_W, 12, sample width in bits, offset-binary (2..16).
- CNT_W, 12, width of the sample index and line length.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- trig  in  1  line start request, level-sampled.
- mode  in  2  pattern select: 0 ramp, 1 const, 2 lfsr, 3 echo.
- line_len  in  CNT_W  samples per line.
- const_val  in  DATA_W  value for const mode.
- echo_pos  in  CNT_W  echo sample index on channel 0.
- echo_step  in  CNT_W  extra echo delay per channel index.
- echo_amp  in  DATA_W  echo sample value.
- data_out  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- data_valid  out  1  data_out holds a valid sample.
- line_done  out  1  one-cycle pulse after the last sample of a line.
- busy  out  1  high in ARM or RUN.
- trig_miss  out  1  one-cycle pulse when trig is high while busy.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = IDLE; all outputs and counters are 0; LFSR = 16'hACE1.
  - Reset mid-line aborts immediately; no line_done is issued.
- FSM states:
  - IDLE: trig=1 at edge E0 → ARM. At the same edge, latch mode, line_len, const_val, echo_pos, echo_step and echo_amp into shadow registers.
  - ARM: one cycle. Clears the sample counter n, loads LFSR = 16'hACE1. If latched line_len==0 → DONE, otherwise → RUN.
  - RUN: data_valid=1 on every cycle. Sample n is registered at edge E(2+n). After sample line_len-1 → DONE.
  - DONE: line_done=1 for exactly one cycle, data_valid=0 → IDLE.
- Line timing:
  - First valid sample is 2 cycles after the trig edge.
  - line_done follows the last sample by 1 cycle.
  - A new trig is accepted in the cycle after DONE at the earliest.
- Live input changes during ARM, RUN or DONE have no effect; only the shadow copies are used.
- trig high while busy (ARM or RUN): ignored; trig_miss pulses that cycle. trig during DONE is also ignored, with no pulse.
- busy = (state==ARM) || (state==RUN).
- data_valid=0: data_out holds its last value; it is not cleared.
- Patterns (channel k, sample n, arithmetic mod 2^DATA_W unless stated):
  - ramp: data = n[DATA_W-1:0] + 16*k; wraps freely.
  - const: data = const_val on all channels.
  - lfsr: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts once per RUN cycle after use. data = lfsr[DATA_W-1:0] XOR k. Sample 0 uses the seed.
  - echo: data = echo_amp when n == echo_pos + k*echo_step, else midscale 2^(DATA_W-1).
    - The target is computed at CNT_W+5 bits with no wrap.
    - A target ≥ line_len produces no echo on that channel.
- Output registers: data_out, data_valid, line_done and trig_miss are all registered (no combinational paths from inputs).

Decomposition:
- Package data_gen_pkg holds:
  - mode encodings: MODE_RAMP, MODE_CONST, MODE_LFSR, MODE_ECHO.
  - FSM state typedef.
  - LFSR_SEED = 16'hACE1 and the LFSR tap mask.
  - RAMP_CH_STEP = 16.
- One natural sub-module: data_gen_lfsr16, with ports clk, reset, load, advance and a 16-bit state output.
- Channel pattern logic is a generate loop over NUM_CH inside the top level.

Test Plan:
- Reset: assert reset mid-RUN of a 100-sample line → outputs go to 0 at once, no line_done. Deassert, trig → a clean line starting at n=0.
- Ramp, line_len=5, defaults:
  - ch0 = 0,1,2,3,4 and ch7 = 112..116.
  - data_valid high for exactly 5 cycles, starting 2 cycles after the trig edge.
  - line_done exactly 1 cycle after the last sample.
- Ramp wrap, line_len=4100: ch0 sample 4096 = 0 and ch1 sample 4080 = 0 (4080+16 = 4096 → 0 mod 4096).
- Echo: echo_pos=10, echo_step=3, echo_amp=4095, line_len=30.
  - Channel k = 4095 only at n = 10+3k; all other samples 2048.
  - echo_step=3, echo_pos=25 → ch2 (target 31) and above show no echo.
- LFSR on two consecutive lines: sequences are identical; ch0 sample0 = 12'hCE1 and ch3 sample0 = 12'hCE2. Const mode with const_val=0x5A5 → all channels = 0x5A5.
- line_len=0: line_done pulses at edge E2 with no data_valid.
  - trig held high through a 3-sample line → trig_miss pulses during ARM and RUN only.
  - A second line starts in the cycle after DONE.
